// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states and
// the default divide iteration count.
package muldiv_pkg;

  localparam int unsigned DIV_ITERS_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct
  // when the result is read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step (
  input  logic [31:0] rem_i,
  input  logic        dividend_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // The shifted remainder can reach 33 bits because the divisor may be up to 2^32-1.
  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~diff[32];
  assign rem_o   = q_bit_o ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// Busy stalls the pipeline while a multiply or divide is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // a_q: multiplicand, or dividend magnitude shifting into quotient. b_q: multiplier/divisor.
  logic [31:0]      a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic             mul_signed_q, mul_signed_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             zero_div_q, zero_div_d;

  logic [63:0] mul_a, mul_b, product;
  logic [31:0] step_rem;
  logic        step_q_bit;
  logic        div_signed;

  assign mul_a   = {(mul_signed_q ? {32{a_q[31]}} : 32'd0), a_q};
  assign mul_b   = {(mul_signed_q ? {32{b_q[31]}} : 32'd0), b_q};
  assign product = mul_a * mul_b;

  div_step u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (a_q[31]),
    .divisor_i      (b_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_q_bit)
  );

  assign div_signed = (Op == OP_DIV);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    dbz_d        = 1'b0;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    mul_signed_d = mul_signed_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    zero_div_d   = zero_div_q;

    if (Flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (Start) begin
          case (Op)
            OP_MTHI: hi_d = OperandA;
            OP_MTLO: lo_d = OperandA;
            OP_MULT, OP_MULTU: begin
              a_d          = OperandA;
              b_d          = OperandB;
              mul_signed_d = (Op == OP_MULT);
              state_d      = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d        = div_signed ? mag32(OperandA) : OperandA;
              b_d        = div_signed ? mag32(OperandB) : OperandB;
              neg_quo_d  = div_signed & (OperandA[31] ^ OperandB[31]);
              neg_rem_d  = div_signed & OperandA[31];
              rem_d      = 32'd0;
              cnt_d      = '0;
              zero_div_d = (OperandB == 32'd0);
              state_d    = (OperandB == 32'd0) ? ST_FIX : ST_DIV;
            end
            default: ;
          endcase
        end
        ST_MUL: begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
        ST_DIV: begin
          rem_d = step_rem;
          a_d   = {a_q[30:0], step_q_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_FIX;
        end
        default: begin  // ST_FIX
          if (zero_div_q) begin
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_quo_q ? -a_q : a_q;
            hi_d = neg_rem_q ? -rem_q : rem_q;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      done_q       <= 1'b0;
      dbz_q        <= 1'b0;
      cnt_q        <= '0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 32'd0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      zero_div_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      done_q       <= done_d;
      dbz_q        <= dbz_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      mul_signed_q <= mul_signed_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      zero_div_q   <= zero_div_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: drives on the falling edge, samples on the
// falling edge, with hand-computed expected values.
module tb_muldiv_unit;

  logic        Clk, Rst, Start, Flush;
  logic [2:0]  Op;
  logic [31:0] OperandA, OperandB;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  muldiv_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op for one cycle, then count Busy cycles (bounded); returns at
  // the first falling edge with Busy low, where Done should be visible.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      @(negedge Clk);
    end
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'b000;
    OperandA = 32'd0; OperandB = 32'd0;
    repeat (2) @(negedge Clk);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_dbz", DivByZero, 0);
    check("reset_hi", Hi, 0);
    check("reset_lo", Lo, 0);
    Rst = 1'b1;

    // MULT -2 * 3
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, busy_cnt);
    check("mult_busy", busy_cnt, 1);
    check("mult_done", Done, 1);
    check("mult_hi", Hi, 32'hFFFF_FFFF);
    check("mult_lo", Lo, 32'hFFFF_FFFA);
    @(negedge Clk);
    check("mult_done_pulse", Done, 0);

    // MULTU 0xFFFFFFFE * 3
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, busy_cnt);
    check("multu_busy", busy_cnt, 1);
    check("multu_done", Done, 1);
    check("multu_hi", Hi, 32'h0000_0002);
    check("multu_lo", Lo, 32'hFFFF_FFFA);

    // DIV -7 / 2
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, busy_cnt);
    check("div_busy", busy_cnt, 33);
    check("div_done", Done, 1);
    check("div_dbz", DivByZero, 0);
    check("div_lo", Lo, 32'hFFFF_FFFD);
    check("div_hi", Hi, 32'hFFFF_FFFF);
    @(negedge Clk);
    check("div_done_pulse", Done, 0);

    // DIVU 100 / 7
    run_op(3'b011, 32'd100, 32'd7, busy_cnt);
    check("divu_busy", busy_cnt, 33);
    check("divu_lo", Lo, 32'd14);
    check("divu_hi", Hi, 32'd2);

    // DIV overflow case wraps
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, busy_cnt);
    check("divovf_done", Done, 1);
    check("divovf_lo", Lo, 32'h8000_0000);
    check("divovf_hi", Hi, 32'h0000_0000);

    // DIVU by zero keeps Hi/Lo
    run_op(3'b011, 32'd5, 32'd0, busy_cnt);
    check("dbz_busy", busy_cnt, 1);
    check("dbz_done", Done, 1);
    check("dbz_flag", DivByZero, 1);
    check("dbz_lo", Lo, 32'h8000_0000);
    check("dbz_hi", Hi, 32'h0000_0000);
    @(negedge Clk);
    check("dbz_flag_pulse", DivByZero, 0);

    // Reserved op ignored
    run_op(3'b110, 32'hDEAD_BEEF, 32'd1, busy_cnt);
    check("rsv_busy", busy_cnt, 0);
    check("rsv_done", Done, 0);
    check("rsv_hi", Hi, 32'h0000_0000);
    check("rsv_lo", Lo, 32'h8000_0000);

    // MTHI then MTLO back to back
    @(negedge Clk);
    Start = 1'b1; Op = 3'b100; OperandA = 32'h1234_5678;
    @(negedge Clk);
    check("mthi_busy", Busy, 0);
    check("mthi_hi", Hi, 32'h1234_5678);
    check("mthi_lo_kept", Lo, 32'h8000_0000);
    Op = 3'b101; OperandA = 32'hCAFE_F00D;
    @(negedge Clk);
    Start = 1'b0;
    check("mtlo_busy", Busy, 0);
    check("mtlo_done", Done, 0);
    check("mtlo_hi_kept", Hi, 32'h1234_5678);
    check("mtlo_lo", Lo, 32'hCAFE_F00D);

    // MULT requested during DIVU 1000/10 is ignored
    @(negedge Clk);
    Start = 1'b1; Op = 3'b011; OperandA = 32'd1000; OperandB = 32'd10;
    @(negedge Clk);
    Op = 3'b000; OperandA = 32'd5; OperandB = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    busy_cnt = 1;
    while (Busy && busy_cnt < 200) begin
      busy_cnt++;
      @(negedge Clk);
    end
    check("ign_busy", busy_cnt, 33);
    check("ign_done", Done, 1);
    check("ign_lo", Lo, 32'd100);
    check("ign_hi", Hi, 32'd0);
    @(negedge Clk);
    check("ign_no_extra_busy", Busy, 0);

    // Flush at DIV cycle 10
    @(negedge Clk);
    Start = 1'b1; Op = 3'b010; OperandA = 32'hFFFF_FFF9; OperandB = 32'd2;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("flush_busy_before", Busy, 1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_busy", Busy, 0);
    check("flush_done", Done, 0);
    check("flush_lo", Lo, 32'd100);
    check("flush_hi", Hi, 32'd0);
    repeat (30) @(negedge Clk);
    check("flush_no_late_done", Done, 0);
    check("flush_lo_late", Lo, 32'd100);

    // Reset at DIV cycle 20
    @(negedge Clk);
    Start = 1'b1; Op = 3'b011; OperandA = 32'd77; OperandB = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    repeat (20) @(negedge Clk);
    check("rst_no_late_done", Done, 0);
    check("rst_lo_late", Lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
